// File: rtl/adder_tree_pkg.sv
// Shared types and helpers for the adder_tree family (gather FSM states, counter width, lane slicing).
package adder_tree_pkg;

  localparam int unsigned CNT_DEF   = 8;
  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } gather_state_e;

  function automatic int unsigned cnt_w(input int unsigned cnt);
    return (cnt > 1) ? $clog2(cnt) : 1;
  endfunction

  function automatic int unsigned lane_lo(input int unsigned i, input int unsigned width);
    return i * width;
  endfunction

endpackage

// File: rtl/adder_tree_gather.sv
// Collects CNT stream words into one parallel frame for adder_tree, with fill + output buffering.
// Optional early frame close on s_last when ADDER_TREE_GATHER_FLUSH_EN is defined.
module adder_tree_gather
  import adder_tree_pkg::*;
#(
  parameter int unsigned CNT   = CNT_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CNT*WIDTH-1:0] m_data
);

  localparam int unsigned CNT_W = cnt_w(CNT);
  localparam int unsigned BUS_W = CNT * WIDTH;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CNT - 1);

  gather_state_e    state_q, state_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [BUS_W-1:0] fill_buf_q, fill_buf_d;
  logic [BUS_W-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             s_ready_q, s_ready_d;

  logic             in_fire_c;
  logic             out_fire_c;
  logic             flush_c;
  logic             close_c;
  logic [BUS_W-1:0] frame_c;

`ifdef ADDER_TREE_GATHER_FLUSH_EN
  assign flush_c = s_last;
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign flush_c       = 1'b0;
`endif

  assign in_fire_c  = s_valid & s_ready_q;
  assign out_fire_c = m_valid_q & m_ready;
  assign close_c    = (fill_cnt_q == LAST_IDX) | flush_c;

  // Fill buffer with the incoming word merged in; lanes past an early close read as zero.
  always_comb begin
    frame_c = fill_buf_q;
    for (int unsigned i = 0; i < CNT; i++) begin
      if (i == 32'(fill_cnt_q)) begin
        frame_c[lane_lo(i, WIDTH) +: WIDTH] = s_data;
      end else if (flush_c && (i > 32'(fill_cnt_q))) begin
        frame_c[lane_lo(i, WIDTH) +: WIDTH] = '0;
      end
    end
  end

  // Next-state and buffer steering.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    fill_buf_d = fill_buf_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q & ~out_fire_c;

    case (state_q)
      FILL: begin
        if (in_fire_c) begin
          fill_buf_d = frame_c;
          if (close_c) begin
            if (!m_valid_q || out_fire_c) begin
              m_data_d   = frame_c;
              m_valid_d  = 1'b1;
              fill_cnt_d = '0;
            end else begin
              state_d = HOLD;
            end
          end else begin
            fill_cnt_d = fill_cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_fire_c) begin
          m_data_d   = fill_buf_q;
          m_valid_d  = 1'b1;
          fill_cnt_d = '0;
          state_d    = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    s_ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
      fill_buf_q <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      s_ready_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      fill_buf_q <= fill_buf_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      s_ready_q  <= s_ready_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

endmodule
